// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: trigger-level encodings,
// receive FIFO entry layout and default character-timeout length.
package uart_pkg;

    localparam int DATA_W            = 8;
    localparam int ENTRY_W           = 10;
    localparam int FRAME_BIT         = 8;
    localparam int PARITY_BIT        = 9;
    localparam int TIMEOUT_TICKS_DEF = 640;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } trig_lvl_e;

    // Field order matches the FRAME_BIT/PARITY_BIT positions above.
    typedef struct packed {
        logic              parity_err;
        logic              frame_err;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with push, pop, flush,
// registered count/full/empty and a head word that reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q;
    logic              doPush, doPop;

    // A pop frees the head slot, so a push into a full FIFO is legal alongside it.
    assign doPop  = pop_i && !empty_q && !flush_i;
    assign doPush = push_i && (!full_q || doPop) && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (doPush) wptr_d = wptr_q + PTR_ONE;
            if (doPop)  rptr_d = rptr_q + PTR_ONE;
            if (doPush && !doPop)      count_d = count_q + CNT_ONE;
            else if (doPop && !doPush) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = empty_q ? '0 : mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT character FIFO plus sticky overrun, error-entry
// tracking, trigger-level interrupt and character-timeout interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_16x,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              rx_frame_err,
    input  logic              rx_parity_err,
    input  logic              rd_en,
    input  logic              fifo_flush,
    input  logic              overrun_clr,
    input  logic [1:0]        trig_lvl,
    output logic [7:0]        rd_data,
    output logic              rd_frame_err,
    output logic              rd_parity_err,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              err_in_fifo,
    output logic              overrun,
    output logic              rx_int_trig,
    output logic              rx_int_timeout
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [9:0]      TO_LIMIT = 10'(TIMEOUT_TICKS);
    localparam logic [9:0]      TO_ONE   = 10'(1);

    rx_entry_t         wrEntry, headEntry;
    logic [ENTRY_W-1:0] headBits;
    logic              push, pop, drop, errInc, errDec;
    logic [ADDR_W:0]   errCnt_q, errCnt_d, trigLevel;
    logic [9:0]        toCnt_q, toCnt_d;
    logic              overrun_q, overrun_d, timeout_q, timeout_d, errFlag_q;

    assign pop  = rd_en && !empty && !fifo_flush;
    assign push = rx_done && (!full || pop) && !fifo_flush;
    assign drop = rx_done && full && !pop && !fifo_flush;

    assign wrEntry = '{parity_err: rx_parity_err, frame_err: rx_frame_err, data: rx_data};

    sync_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (fifo_flush),
        .wdata_i (wrEntry),
        .rdata_o (headBits),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign headEntry     = rx_entry_t'(headBits);
    assign rd_data       = headEntry.data;
    assign rd_frame_err  = headEntry.frame_err;
    assign rd_parity_err = headEntry.parity_err;

    assign errInc = push && (rx_frame_err || rx_parity_err);
    assign errDec = pop && (headEntry.frame_err || headEntry.parity_err);

    always_comb begin
        errCnt_d  = errCnt_q;
        overrun_d = overrun_q;
        if (fifo_flush)          errCnt_d = '0;
        else if (errInc && !errDec) errCnt_d = errCnt_q + CNT_ONE;
        else if (errDec && !errInc) errCnt_d = errCnt_q - CNT_ONE;
        // A fresh drop wins over a clear arriving in the same cycle.
        if (drop)             overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
    end

    // Timeout counts idle ticks only while characters sit unread.
    always_comb begin
        toCnt_d   = toCnt_q;
        timeout_d = timeout_q;
        if (push || pop || fifo_flush || empty) begin
            toCnt_d = '0;
        end else if (tick_16x && toCnt_q != TO_LIMIT) begin
            toCnt_d = toCnt_q + TO_ONE;
        end
        if (push || pop || fifo_flush) begin
            timeout_d = 1'b0;
        end else if (toCnt_d == TO_LIMIT && !empty) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q  <= '0;
            errFlag_q <= 1'b0;
            overrun_q <= 1'b0;
            toCnt_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            errCnt_q  <= errCnt_d;
            errFlag_q <= (errCnt_d != '0);
            overrun_q <= overrun_d;
            toCnt_q   <= toCnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        trigLevel = CNT_ONE;
        case (trig_lvl_e'(trig_lvl))
            TRIG_1:  trigLevel = CNT_ONE;
            TRIG_4:  trigLevel = (ADDR_W + 1)'(4);
            TRIG_8:  trigLevel = (ADDR_W + 1)'(8);
            TRIG_14: trigLevel = (ADDR_W + 1)'(DEPTH - 2);
            default: trigLevel = CNT_ONE;
        endcase
    end

    assign rx_int_trig    = !empty && (count >= trigLevel);
    assign err_in_fifo    = errFlag_q;
    assign overrun        = overrun_q;
    assign rx_int_timeout = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TICKS  = 640;

    logic clk = 1'b0, rst_n = 1'b0, tick_16x = 1'b0, rx_done = 1'b0;
    logic [7:0] rx_data = '0;
    logic rx_frame_err = 1'b0, rx_parity_err = 1'b0, rd_en = 1'b0;
    logic fifo_flush = 1'b0, overrun_clr = 1'b0;
    logic [1:0] trig_lvl = 2'b00;

    logic [7:0] rd_data;
    logic rd_frame_err, rd_parity_err, empty, full, err_in_fifo, overrun;
    logic rx_int_trig, rx_int_timeout;
    logic [ADDR_W:0] count;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    logic [9:0] mq[$];
    bit mOverrun = 1'b0;
    int mToCnt = 0;
    bit mToInt = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_TICKS(TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx_done(rx_done),
        .rx_data(rx_data), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .rd_en(rd_en), .fifo_flush(fifo_flush), .overrun_clr(overrun_clr),
        .trig_lvl(trig_lvl), .rd_data(rd_data), .rd_frame_err(rd_frame_err),
        .rd_parity_err(rd_parity_err), .empty(empty), .full(full), .count(count),
        .err_in_fifo(err_in_fifo), .overrun(overrun), .rx_int_trig(rx_int_trig),
        .rx_int_timeout(rx_int_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int levelOf(input logic [1:0] l);
        case (l)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return DEPTH - 2;
        endcase
    endfunction

    function automatic bit anyErr();
        foreach (mq[i]) if (mq[i][9:8] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled.
    function automatic void modelStep();
        bit popOk, pushOk, wasEmpty;
        wasEmpty = (mq.size() == 0);
        if (fifo_flush) begin
            mq.delete();
            mToCnt = 0;
            mToInt = 1'b0;
            if (overrun_clr) mOverrun = 1'b0;
            return;
        end
        popOk  = rd_en && !wasEmpty;
        pushOk = rx_done && (mq.size() < DEPTH || popOk);
        if (popOk) void'(mq.pop_front());
        if (pushOk) mq.push_back({rx_parity_err, rx_frame_err, rx_data});
        if (rx_done && !pushOk) mOverrun = 1'b1;
        else if (overrun_clr) mOverrun = 1'b0;
        if (pushOk || popOk) begin
            mToCnt = 0;
            mToInt = 1'b0;
        end else if (wasEmpty) begin
            mToCnt = 0;
        end else begin
            if (tick_16x && mToCnt < TICKS) mToCnt++;
            if (mToCnt == TICKS) mToInt = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            int sz;
            logic [9:0] head;
            sz = mq.size();
            head = '0;
            if (sz > 0) head = mq[0];
            checkOutput("count", count, sz);
            checkOutput("empty", empty, int'(sz == 0));
            checkOutput("full", full, int'(sz == DEPTH));
            checkOutput("rd_data", rd_data, head[7:0]);
            checkOutput("rd_frame_err", rd_frame_err, head[8]);
            checkOutput("rd_parity_err", rd_parity_err, head[9]);
            checkOutput("err_in_fifo", err_in_fifo, anyErr());
            checkOutput("overrun", overrun, mOverrun);
            checkOutput("rx_int_trig", rx_int_trig, int'(sz > 0 && sz >= levelOf(trig_lvl)));
            checkOutput("rx_int_timeout", rx_int_timeout, mToInt);
        end
    end

    task automatic applyStimulus(input logic done, input logic [7:0] d, input logic fe,
                                 input logic pe, input logic rd, input logic fl,
                                 input logic oc, input logic tk);
        rx_done = done; rx_data = d; rx_frame_err = fe; rx_parity_err = pe;
        rd_en = rd; fifo_flush = fl; overrun_clr = oc; tick_16x = tk;
        @(posedge clk);
        #1;
        modelStep();
    endtask

    task automatic pushChar(input logic [7:0] d, input logic fe, input logic pe);
        applyStimulus(1'b1, d, fe, pe, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic popChar();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic tk);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_err", err_in_fifo, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_timeout", rx_int_timeout, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        checkEn = 1'b1;

        pushChar(8'h41, 0, 0); pushChar(8'h42, 0, 0); pushChar(8'h55, 0, 0);
        checkOutput("ord_count3", count, 3);
        checkOutput("ord_head0", rd_data, 8'h41); popChar();
        checkOutput("ord_head1", rd_data, 8'h42); popChar();
        checkOutput("ord_head2", rd_data, 8'h55); popChar();
        checkOutput("ord_empty", empty, 1);
        checkOutput("ord_overrun", overrun, 0);

        for (int i = 0; i <= 16; i++) pushChar(8'(i), 0, 0);
        checkOutput("ovr_full", full, 1);
        checkOutput("ovr_count", count, 16);
        checkOutput("ovr_flag", overrun, 1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("ovr_order", rd_data, i);
            popChar();
        end
        checkOutput("ovr_drained", empty, 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 0);
        checkOutput("ovr_clr", overrun, 0);

        for (int i = 0; i < 16; i++) pushChar(8'(i), 0, 0);
        applyStimulus(1, 8'hAA, 0, 0, 1, 0, 0, 0);
        checkOutput("fullrw_count", count, 16);
        checkOutput("fullrw_overrun", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) checkOutput("fullrw_last", rd_data, 8'hAA);
            popChar();
        end

        trig_lvl = 2'b01;
        for (int i = 0; i < 3; i++) pushChar(8'(8'h60 + i), 0, 0);
        checkOutput("trig_3", rx_int_trig, 0);
        pushChar(8'h63, 0, 0);
        checkOutput("trig_4", rx_int_trig, 1);
        popChar();
        checkOutput("trig_pop", rx_int_trig, 0);
        repeat (3) popChar();

        pushChar(8'h77, 0, 0);
        for (int i = 0; i < TICKS - 1; i++) idle(1'b1);
        checkOutput("to_639", rx_int_timeout, 0);
        idle(1'b1);
        checkOutput("to_640", rx_int_timeout, 1);
        popChar();
        checkOutput("to_cleared", rx_int_timeout, 0);

        pushChar(8'h11, 1, 0); pushChar(8'h22, 0, 0);
        checkOutput("err_flag", err_in_fifo, 1);
        checkOutput("err_head_fe", rd_frame_err, 1);
        popChar();
        checkOutput("err_cleared", err_in_fifo, 0);
        pushChar(8'h33, 0, 1);
        applyStimulus(1, 8'h44, 0, 0, 0, 1, 0, 0);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_err", err_in_fifo, 0);
        checkOutput("flush_to", rx_int_timeout, 0);
        checkOutput("flush_overrun", overrun, 0);

        for (int i = 0; i < 4000; i++) begin
            int pPush, pPop;
            if (((i / 400) % 2) == 0) begin pPush = 70; pPop = 25; end
            else begin pPush = 25; pPop = 70; end
            if ($urandom_range(99) < 2) trig_lvl = 2'($urandom_range(3));
            applyStimulus($urandom_range(99) < pPush, 8'($urandom), $urandom_range(99) < 10,
                          $urandom_range(99) < 10, $urandom_range(99) < pPop,
                          $urandom_range(99) < 1, $urandom_range(99) < 3,
                          $urandom_range(99) < 60);
        end
        idle(1'b0);
        @(negedge clk);
        #1;
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
